// File: rtl/bist_resp_analyzer_pkg.sv
// Shared definitions for the BIST response analyzer: FSM state encodings and
// default SISR constants, also reused by the pattern-source side of the test loop.
package bist_resp_analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int          DEF_SIG_W   = 16;
  localparam logic [15:0] DEF_POLY    = 16'h1021;
  localparam logic [15:0] DEF_SEED    = 16'hFFFF;
  localparam int          DEF_NUM_PAT = 256;
  localparam int          DEF_CNT_W   = 9;

endpackage

// File: rtl/bist_resp_analyzer_sisr.sv
// Combinational next-state of the serial signature register: folds one response
// bit into the current signature using the feedback polynomial (top term implied).
module bist_resp_analyzer_sisr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic [SIG_W-1:0] sig,
  input  logic             resp_bit,
  output logic [SIG_W-1:0] sig_next
);

  logic fb;

  always_comb begin
    fb       = sig[SIG_W-1] ^ resp_bit;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/bist_resp_analyzer.sv
// Capture/compare end of the BIST loop: compacts accepted CUT responses into a
// SISR, counts them, and compares the final signature against a golden value.
module bist_resp_analyzer
  import bist_resp_analyzer_pkg::*;
#(
  parameter int               SIG_W   = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter int               NUM_PAT = DEF_NUM_PAT,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic             resp_bit,
  input  logic [SIG_W-1:0] golden,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] resp_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAT - 1);

  bist_state_t      state, state_next;
  logic [SIG_W-1:0] sig_next;
  logic             accept;
  logic             last_accept;

  bist_resp_analyzer_sisr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_sisr (
    .sig      (signature),
    .resp_bit (resp_bit),
    .sig_next (sig_next)
  );

  assign resp_ready  = (state == RUN);
  assign busy        = (state == RUN) || (state == CHECK);
  assign accept      = resp_valid & resp_ready;
  assign last_accept = accept && (resp_count == LAST_IDX);

  // abort outranks the final accept, so a run can always be cancelled
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN: begin
        if (abort)            state_next = IDLE;
        else if (last_accept) state_next = CHECK;
      end
      CHECK:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      signature  <= SEED;
      resp_count <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature  <= SEED;
            resp_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          // aborted runs keep signature/count visible for debug
          if (abort) begin
            done <= 1'b0;
            pass <= 1'b0;
          end else if (accept) begin
            signature  <= sig_next;
            resp_count <= resp_count + 1'b1;
          end
        end
        CHECK: begin
          pass <= (signature == golden);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Directed bench for bist_resp_analyzer with a 4-response run; expected
// signatures are hand-computed from the SISR recurrence with POLY 16'h1021.
module tb_bist_resp_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        resp_valid;
  logic        resp_bit;
  logic [15:0] golden;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [8:0]  resp_count;

  int vectors    = 0;
  int miscompares = 0;

  bist_resp_analyzer #(
    .NUM_PAT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .resp_valid (resp_valid),
    .resp_bit   (resp_bit),
    .golden     (golden),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .resp_count (resp_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " sig"},   32'(signature),  32'hFFFF);
    checkOutput({tag, " cnt"},   32'(resp_count), 32'd0);
    checkOutput({tag, " done"},  32'(done),       32'd0);
    checkOutput({tag, " pass"},  32'(pass),       32'd0);
    checkOutput({tag, " busy"},  32'(busy),       32'd0);
    checkOutput({tag, " ready"}, 32'(resp_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    resp_valid = 1'b0; resp_bit = 1'b0; golden = 16'h0E1F;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(1);

    // 1: reset mid-clock during a run takes effect immediately
    start = 1'b1; applyStimulus(1); start = 1'b0;
    resp_valid = 1'b1; applyStimulus(1); resp_valid = 1'b0;
    checkOutput("t1 pre-reset sig", 32'(signature), 32'hEFDF);
    @(negedge clk); rst = 1'b1; #1;
    checkIdleOutputs("t1 async reset");
    applyStimulus(1); rst = 1'b0; applyStimulus(1);

    // 2: four back-to-back zero responses, matching golden
    golden = 16'h0E1F;
    start = 1'b1; applyStimulus(1); start = 1'b0;
    checkOutput("t2 busy", 32'(busy), 32'd1);
    checkOutput("t2 ready", 32'(resp_ready), 32'd1);
    resp_valid = 1'b1; resp_bit = 1'b0;
    applyStimulus(1); checkOutput("t2 sig1", 32'(signature), 32'hEFDF);
    applyStimulus(1); checkOutput("t2 sig2", 32'(signature), 32'hCF9F);
    applyStimulus(1); checkOutput("t2 sig3", 32'(signature), 32'h8F1F);
    applyStimulus(1); checkOutput("t2 sig4", 32'(signature), 32'h0E1F);
    resp_valid = 1'b0;
    checkOutput("t2 check ready", 32'(resp_ready), 32'd0);
    checkOutput("t2 check busy", 32'(busy), 32'd1);
    checkOutput("t2 check done", 32'(done), 32'd0);
    checkOutput("t2 count", 32'(resp_count), 32'd4);
    applyStimulus(1);
    checkOutput("t2 done", 32'(done), 32'd1);
    checkOutput("t2 pass", 32'(pass), 32'd1);
    checkOutput("t2 idle busy", 32'(busy), 32'd0);
    applyStimulus(2);
    checkOutput("t2 done held", 32'(done), 32'd1);

    // 3: same stream with gaps on alternate cycles
    start = 1'b1; applyStimulus(1); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resp_valid = (i % 2 == 1);
      applyStimulus(1);
      if (i == 2) begin
        checkOutput("t3 stall sig", 32'(signature), 32'hEFDF);
        checkOutput("t3 stall cnt", 32'(resp_count), 32'd1);
      end
    end
    resp_valid = 1'b0;
    checkOutput("t3 sig", 32'(signature), 32'h0E1F);
    applyStimulus(1);
    checkOutput("t3 done", 32'(done), 32'd1);
    checkOutput("t3 pass", 32'(pass), 32'd1);

    // 4: wrong golden gives done without pass; restart clears
    golden = 16'h0E1E;
    start = 1'b1; applyStimulus(1); start = 1'b0;
    resp_valid = 1'b1; applyStimulus(4); resp_valid = 1'b0;
    applyStimulus(1);
    checkOutput("t4 done", 32'(done), 32'd1);
    checkOutput("t4 pass", 32'(pass), 32'd0);
    start = 1'b1; applyStimulus(1); start = 1'b0;
    checkOutput("t4 restart done", 32'(done), 32'd0);
    checkOutput("t4 restart sig", 32'(signature), 32'hFFFF);
    checkOutput("t4 restart cnt", 32'(resp_count), 32'd0);

    // 5: start during RUN ignored, abort beats accept and holds sig/count
    resp_valid = 1'b1; applyStimulus(2); resp_valid = 1'b0;
    start = 1'b1; applyStimulus(1); start = 1'b0;
    checkOutput("t5 start ignored busy", 32'(busy), 32'd1);
    checkOutput("t5 start ignored cnt", 32'(resp_count), 32'd2);
    abort = 1'b1; resp_valid = 1'b1; resp_bit = 1'b1;
    applyStimulus(1);
    abort = 1'b0; resp_valid = 1'b0; resp_bit = 1'b0;
    checkOutput("t5 abort busy", 32'(busy), 32'd0);
    checkOutput("t5 abort ready", 32'(resp_ready), 32'd0);
    checkOutput("t5 abort sig", 32'(signature), 32'hCF9F);
    checkOutput("t5 abort cnt", 32'(resp_count), 32'd2);
    checkOutput("t5 abort done", 32'(done), 32'd0);
    start = 1'b1; abort = 1'b1; applyStimulus(1); start = 1'b0; abort = 1'b0;
    checkOutput("t5 start+abort busy", 32'(busy), 32'd1);
    checkOutput("t5 start+abort sig", 32'(signature), 32'hFFFF);

    // 6: reset while in CHECK; done never appears
    golden = 16'h0E1F;
    resp_valid = 1'b1; applyStimulus(4); resp_valid = 1'b0;
    checkOutput("t6 in check busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    checkIdleOutputs("t6 reset in check");
    applyStimulus(1); rst = 1'b0; applyStimulus(2);
    checkOutput("t6 done after", 32'(done), 32'd0);
    checkOutput("t6 pass after", 32'(pass), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
